// File: rtl/mem_pkg.sv
// Shared memory-path definitions: load type codes, exception codes and the address map
// used by the load unit, the store path and the peripheral bridge.
package mem_pkg;

  localparam logic [2:0] LOAD_NONE = 3'd0;
  localparam logic [2:0] LOAD_LW   = 3'd1;
  localparam logic [2:0] LOAD_LB   = 3'd2;
  localparam logic [2:0] LOAD_LBU  = 3'd3;
  localparam logic [2:0] LOAD_LH   = 3'd4;
  localparam logic [2:0] LOAD_LHU  = 3'd5;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam logic [31:0] ADDR_DM_BYTES    = 32'h0000_3000;
  localparam logic [31:0] ADDR_TIMER0_BASE = 32'h0000_7F00;
  localparam logic [31:0] ADDR_TIMER1_BASE = 32'h0000_7F10;
  localparam logic [31:0] ADDR_TIMER_SPAN  = 32'h0000_000C;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic [4:0]  dest;
    logic        reg_write;
    logic        is_load;
  } w_entry_t;

  // Half-open window test [base, base+span).
  function automatic logic in_window(input logic [31:0] a, input logic [31:0] base,
                                     input logic [31:0] span);
    return (a >= base) && (a < base + span);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational byte/halfword extraction and sign/zero extension of a read word.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  load_type,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = word[8*off +: 8];
    h    = word[16*off[1] +: 16];
    data = '0;
    case (load_type)
      LOAD_LW:  data = word;
      LOAD_LB:  data = {{24{b[7]}}, b};
      LOAD_LBU: data = {24'd0, b};
      LOAD_LH:  data = {{16{h[15]}}, h};
      LOAD_LHU: data = {16'd0, h};
      default:  data = '0;
    endcase
  end

endmodule

// File: rtl/mw_load_unit.sv
// M->W load boundary: AdEL check, DM/peripheral select, load extension and W registers.
module mw_load_unit
  import mem_pkg::*;
#(
  parameter logic [31:0] DM_BYTES    = ADDR_DM_BYTES,
  parameter logic [31:0] TIMER0_BASE = ADDR_TIMER0_BASE,
  parameter logic [31:0] TIMER1_BASE = ADDR_TIMER1_BASE,
  parameter logic [31:0] TIMER_SPAN  = ADDR_TIMER_SPAN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] m_pc,
  input  logic [31:0] m_addr,
  input  logic [2:0]  m_load_type,
  input  logic [4:0]  m_dest,
  input  logic        m_reg_write,
  input  logic [31:0] m_dm_rdata,
  input  logic [31:0] m_dev_rdata,
  output logic        m_exc_adel,
  output logic [4:0]  m_exc_code,
  output logic [31:0] w_pc,
  output logic [31:0] w_data,
  output logic [4:0]  w_dest,
  output logic        w_reg_write,
  output logic        w_is_load
);

  logic        is_load, is_lw, is_half;
  logic        dm_hit, dev_hit;
  logic [31:0] raw_word, ext_data;
  w_entry_t    w_q;

  // Types 6/7 fall out of is_load and behave exactly like a non-load.
  always_comb begin
    is_load = (m_load_type >= LOAD_LW) && (m_load_type <= LOAD_LHU);
    is_lw   = (m_load_type == LOAD_LW);
    is_half = (m_load_type == LOAD_LH) || (m_load_type == LOAD_LHU);
    dm_hit  = (m_addr < DM_BYTES);
    dev_hit = in_window(m_addr, TIMER0_BASE, TIMER_SPAN) ||
              in_window(m_addr, TIMER1_BASE, TIMER_SPAN);
    m_exc_adel = is_load && ((is_lw && (m_addr[1:0] != 2'b00)) ||
                             (is_half && m_addr[0]) ||
                             (!dm_hit && !dev_hit) ||
                             (dev_hit && !is_lw));
    m_exc_code = m_exc_adel ? EXC_ADEL : 5'd0;
    raw_word   = dev_hit ? m_dev_rdata : m_dm_rdata;
  end

  load_extend u_ext (
    .word      (raw_word),
    .off       (m_addr[1:0]),
    .load_type (m_load_type),
    .data      (ext_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q <= '0;
    end else if (flush) begin
      w_q    <= '0;
      w_q.pc <= m_pc;
    end else if (!stall) begin
      w_q.pc        <= m_pc;
      w_q.dest      <= m_dest;
      w_q.reg_write <= m_reg_write && !m_exc_adel;
      w_q.is_load   <= is_load && !m_exc_adel;
      w_q.data      <= (is_load && !m_exc_adel) ? ext_data : 32'd0;
    end
  end

  assign w_pc        = w_q.pc;
  assign w_data      = w_q.data;
  assign w_dest      = w_q.dest;
  assign w_reg_write = w_q.reg_write;
  assign w_is_load   = w_q.is_load;

endmodule

// File: tb/tb_mw_load_unit.sv
// Scoreboard bench for mw_load_unit: expected W entries are queued at drive time and
// compared one cycle later; AdEL outputs are checked combinationally.
module tb_mw_load_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic [4:0]  dest;
    logic        rw;
    logic        ld;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, stall, flush, m_reg_write;
  logic [31:0] m_pc, m_addr, m_dm_rdata, m_dev_rdata;
  logic [2:0]  m_load_type;
  logic [4:0]  m_dest;
  logic        m_exc_adel, w_reg_write, w_is_load;
  logic [4:0]  m_exc_code, w_dest;
  logic [31:0] w_pc, w_data;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t q[$];
  exp_t mdl = '{pc: 32'd0, data: 32'd0, dest: 5'd0, rw: 1'b0, ld: 1'b0};

  always #5 clk = ~clk;

  mw_load_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .m_pc(m_pc), .m_addr(m_addr), .m_load_type(m_load_type), .m_dest(m_dest),
    .m_reg_write(m_reg_write), .m_dm_rdata(m_dm_rdata), .m_dev_rdata(m_dev_rdata),
    .m_exc_adel(m_exc_adel), .m_exc_code(m_exc_code),
    .w_pc(w_pc), .w_data(w_data), .w_dest(w_dest),
    .w_reg_write(w_reg_write), .w_is_load(w_is_load)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic is_dev(input logic [31:0] a);
    return (a >= 32'h7F00 && a <= 32'h7F0B) || (a >= 32'h7F10 && a <= 32'h7F1B);
  endfunction

  function automatic logic model_adel(input logic [2:0] lt, input logic [31:0] a);
    logic mapped;
    mapped = (a <= 32'h2FFF) || is_dev(a);
    case (lt)
      3'd1:       return (a[1:0] != 2'b00) || !mapped;
      3'd2, 3'd3: return !mapped || is_dev(a);
      3'd4, 3'd5: return a[0] || !mapped || is_dev(a);
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_data(input logic [2:0] lt, input logic [31:0] a,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (a[1:0])
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (lt)
      3'd1: return w;
      3'd2: return b[7] ? {24'hFFFFFF, b} : {24'h0, b};
      3'd3: return {24'h0, b};
      3'd4: return h[15] ? {16'hFFFF, h} : {16'h0, h};
      3'd5: return {16'h0, h};
      default: return 32'd0;
    endcase
  endfunction

  // One cycle of stimulus: applied after negedge, AdEL checked, next W state queued.
  task automatic drive(input logic rst, input logic fl, input logic st, input logic [2:0] lt,
                       input logic [31:0] a, input logic [31:0] dm, input logic [31:0] dev,
                       input logic [4:0] d, input logic rw, input logic [31:0] pc);
    logic adel, ld;
    @(negedge clk);
    reset = rst; flush = fl; stall = st; m_load_type = lt; m_addr = a;
    m_dm_rdata = dm; m_dev_rdata = dev; m_dest = d; m_reg_write = rw; m_pc = pc;
    #1;
    adel = model_adel(lt, a);
    ld   = (lt >= 3'd1) && (lt <= 3'd5);
    chk("m_exc_adel", {31'd0, m_exc_adel}, {31'd0, adel});
    chk("m_exc_code", {27'd0, m_exc_code}, adel ? 32'd4 : 32'd0);
    if (rst) begin
      mdl = '{pc: 32'd0, data: 32'd0, dest: 5'd0, rw: 1'b0, ld: 1'b0};
    end else if (fl) begin
      mdl = '{pc: pc, data: 32'd0, dest: 5'd0, rw: 1'b0, ld: 1'b0};
    end else if (!st) begin
      mdl.pc   = pc;
      mdl.dest = d;
      mdl.rw   = rw && !adel;
      mdl.ld   = ld && !adel;
      mdl.data = (ld && !adel) ? model_data(lt, a, is_dev(a) ? dev : dm) : 32'd0;
    end
    q.push_back(mdl);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("w_pc",        w_pc, e.pc);
      chk("w_data",      w_data, e.data);
      chk("w_dest",      {27'd0, w_dest}, {27'd0, e.dest});
      chk("w_reg_write", {31'd0, w_reg_write}, {31'd0, e.rw});
      chk("w_is_load",   {31'd0, w_is_load}, {31'd0, e.ld});
    end
  end

  initial begin
    logic [31:0] a, pool_sel;
    //    rst fl st lt    addr          dm            dev           d      rw  pc
    drive(1, 0, 0, 3'd0, 32'h0,        32'h0,        32'h0,        5'd0,  0, 32'h0);
    drive(1, 0, 0, 3'd0, 32'h0,        32'h0,        32'h0,        5'd0,  0, 32'h0);
    // Directed cases
    drive(0, 0, 0, 3'd2, 32'h1003,     32'h80ABCDEF, 32'h0,        5'd3,  1, 32'h3000);
    drive(0, 0, 0, 3'd5, 32'h0002,     32'h80011234, 32'h0,        5'd4,  1, 32'h3004);
    drive(0, 0, 0, 3'd4, 32'h0002,     32'h80011234, 32'h0,        5'd5,  1, 32'h3008);
    drive(0, 0, 0, 3'd1, 32'h7F04,     32'hDEADBEEF, 32'h5,        5'd6,  1, 32'h300C);
    drive(0, 0, 0, 3'd4, 32'h7F00,     32'h0,        32'h5,        5'd7,  1, 32'h3010);
    drive(0, 0, 0, 3'd1, 32'h1002,     32'h11111111, 32'h0,        5'd8,  1, 32'h3014);
    drive(0, 0, 0, 3'd1, 32'h3000,     32'h22222222, 32'h0,        5'd9,  1, 32'h3018);
    drive(0, 0, 0, 3'd1, 32'h2FFC,     32'h33333333, 32'h0,        5'd10, 1, 32'h301C);
    drive(0, 0, 0, 3'd1, 32'h7F1C,     32'h0,        32'h44,       5'd11, 1, 32'h3020);
    drive(0, 0, 0, 3'd1, 32'h7F18,     32'h0,        32'h55,       5'd11, 1, 32'h3024);
    drive(0, 0, 0, 3'd0, 32'hFFFF0001, 32'h12345678, 32'h0,        5'd12, 1, 32'h3028);
    drive(0, 0, 0, 3'd7, 32'h0003,     32'h12345678, 32'h0,        5'd13, 1, 32'h302C);
    drive(0, 0, 0, 3'd3, 32'h0001,     32'h0000FF00, 32'h0,        5'd14, 1, 32'h3030);
    // Capture, stall three cycles with changing inputs, then flush with a new load
    drive(0, 0, 0, 3'd1, 32'h0100,     32'h00001234, 32'h0,        5'd15, 1, 32'h3034);
    drive(0, 0, 1, 3'd1, 32'h0104,     32'hAAAAAAAA, 32'h0,        5'd16, 1, 32'h3038);
    drive(0, 0, 1, 3'd2, 32'h0105,     32'hBBBBBBBB, 32'h0,        5'd17, 1, 32'h303C);
    drive(0, 0, 1, 3'd1, 32'h3000,     32'hCCCCCCCC, 32'h0,        5'd18, 1, 32'h3040);
    drive(0, 1, 0, 3'd1, 32'h0108,     32'hDDDDDDDD, 32'h0,        5'd19, 1, 32'h3044);
    // Reset together with flush and a valid load, then a normal load
    drive(1, 1, 0, 3'd1, 32'h010C,     32'hEEEEEEEE, 32'h0,        5'd20, 1, 32'h3048);
    drive(0, 0, 0, 3'd1, 32'h0110,     32'hCAFEF00D, 32'h0,        5'd21, 1, 32'h304C);
    // Random traffic around the region boundaries
    for (int i = 0; i < 60; i++) begin
      pool_sel = $urandom_range(0, 4);
      case (pool_sel)
        0: a = $urandom_range(0, 32'h2FFF);
        1: a = 32'h7F00 + $urandom_range(0, 32'h1F);
        2: a = 32'h2FF8 + $urandom_range(0, 15);
        3: a = $urandom;
        default: a = $urandom_range(0, 32'h7FFF);
      endcase
      drive(0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
            3'($urandom_range(0, 7)), a, $urandom, $urandom,
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom);
    end
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
